// File: rtl/keypad_scan_ctrl.sv
// 4x4 matrix keypad scanner: drives one row low at a time, samples the columns once per
// row, debounces whole-frame results and hands accepted key presses to a ready/valid consumer.
module keypad_scan_ctrl #(
   parameter int unsigned SCAN_CNT   = 50000,
   parameter int unsigned DEB_FRAMES = 3
) (
   input  logic       clk,
   input  logic       rst,
   output logic [3:0] row,
   input  logic [3:0] col,
   output logic [3:0] key_code,
   output logic       key_valid,
   input  logic       key_ready,
   output logic       overflow
);

   localparam logic [15:0] DWELL_LAST = 16'(SCAN_CNT - 1);
   localparam logic [3:0]  DEB_TARGET = 4'(DEB_FRAMES);

   typedef enum logic [1:0] {
      FRAME_NONE,
      FRAME_SINGLE,
      FRAME_MULTI
   } frame_class_t;

   typedef enum logic {
      RELEASED,
      PRESSED
   } deb_state_t;

   logic [3:0]   col_meta;
   logic [3:0]   col_sync;
   logic [15:0]  dwell_cnt;
   logic [1:0]   row_idx;
   logic         sample_now;
   logic         frame_end;
   logic [1:0]   acc_cnt;
   logic [3:0]   acc_code;
   logic [1:0]   cur_cnt;
   logic [1:0]   cur_col;
   logic [2:0]   tot_raw;
   logic [1:0]   tot_cnt;
   logic [3:0]   frame_code;
   frame_class_t frame_class;
   frame_class_t prev_class;
   logic [3:0]   prev_code;
   logic         same_frame;
   logic [3:0]   stable_cnt;
   logic [3:0]   stable_next;
   deb_state_t   state;
   logic         press_event;

   // The columns are asynchronous to clk; only col_sync is ever looked at.
   always_ff @(posedge clk) begin
      if (rst) begin
         col_meta <= 4'b1111;
         col_sync <= 4'b1111;
      end else begin
         col_meta <= col;
         col_sync <= col_meta;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         dwell_cnt <= '0;
         row_idx   <= '0;
         row       <= 4'b1110;
      end else if (sample_now) begin
         dwell_cnt <= '0;
         row_idx   <= row_idx + 2'd1;
         row       <= ~(4'b0001 << (row_idx + 2'd1));
      end else begin
         dwell_cnt <= dwell_cnt + 16'd1;
      end
   end

   assign sample_now = (dwell_cnt == DWELL_LAST);
   assign frame_end  = sample_now && (row_idx == 2'd3);

   // Low-column counts saturate at 2, which is all that is needed to tell MULTI apart.
   always_comb begin
      cur_cnt = '0;
      cur_col = '0;
      for (int i = 0; i < 4; i++) begin
         if (!col_sync[i]) begin
            cur_col = 2'(i);
            if (cur_cnt != 2'd2) begin
               cur_cnt = cur_cnt + 2'd1;
            end
         end
      end
      tot_raw    = {1'b0, acc_cnt} + {1'b0, cur_cnt};
      tot_cnt    = (tot_raw >= 3'd2) ? 2'd2 : tot_raw[1:0];
      frame_code = (acc_cnt != 2'd0) ? acc_code : {row_idx, cur_col};
      case (tot_cnt)
         2'd0:    frame_class = FRAME_NONE;
         2'd1:    frame_class = FRAME_SINGLE;
         default: frame_class = FRAME_MULTI;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         acc_cnt  <= '0;
         acc_code <= '0;
      end else if (sample_now) begin
         if (row_idx == 2'd3) begin
            acc_cnt  <= '0;
            acc_code <= '0;
         end else begin
            acc_cnt  <= tot_cnt;
            acc_code <= frame_code;
         end
      end
   end

   always_comb begin
      same_frame = (frame_class == prev_class) &&
                   ((frame_class != FRAME_SINGLE) || (frame_code == prev_code));
      if (!same_frame) begin
         stable_next = 4'd1;
      end else if (stable_cnt >= DEB_TARGET) begin
         stable_next = DEB_TARGET;
      end else begin
         stable_next = stable_cnt + 4'd1;
      end
      press_event = frame_end && (state == RELEASED) &&
                    (frame_class == FRAME_SINGLE) && (stable_next == DEB_TARGET);
   end

   // Debounce FSM and the consumer-facing event register share one clocked block so the
   // event lands exactly one cycle after the frame-end sample.
   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= RELEASED;
         stable_cnt <= '0;
         prev_class <= FRAME_NONE;
         prev_code  <= '0;
         key_code   <= '0;
         key_valid  <= 1'b0;
         overflow   <= 1'b0;
      end else begin
         if (frame_end) begin
            stable_cnt <= stable_next;
            prev_class <= frame_class;
            prev_code  <= frame_code;
            case (state)
               RELEASED: begin
                  if ((frame_class == FRAME_SINGLE) && (stable_next == DEB_TARGET)) begin
                     state <= PRESSED;
                  end
               end
               PRESSED: begin
                  if ((frame_class == FRAME_NONE) && (stable_next == DEB_TARGET)) begin
                     state <= RELEASED;
                  end
               end
               default: state <= RELEASED;
            endcase
         end

         if (key_valid && key_ready) begin
            if (press_event) begin
               key_code <= frame_code;
            end else begin
               key_valid <= 1'b0;
            end
         end else if (key_valid) begin
            if (press_event) begin
               overflow <= 1'b1;
            end
         end else if (press_event) begin
            key_code  <= frame_code;
            key_valid <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_keypad_scan_ctrl.sv
// Directed bench for keypad_scan_ctrl: a combinational keypad matrix model driven by a
// 16-bit pressed-key mask, with hand-computed event timing for SCAN_CNT=10, DEB_FRAMES=2.
module tb_keypad_scan_ctrl;

   localparam int SCAN = 10;
   localparam int DEB  = 2;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [3:0]  row;
   logic [3:0]  col;
   logic [3:0]  key_code;
   logic        key_valid;
   logic        key_ready = 1'b1;
   logic        overflow;
   logic [15:0] keys = '0;

   int          k = 0;
   int          vectors = 0;
   int          miscompares = 0;
   int          ev_count = 0;
   logic [3:0]  last_code = '0;

   keypad_scan_ctrl #(
      .SCAN_CNT   (SCAN),
      .DEB_FRAMES (DEB)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .row       (row),
      .col       (col),
      .key_code  (key_code),
      .key_valid (key_valid),
      .key_ready (key_ready),
      .overflow  (overflow)
   );

   always #10 clk = ~clk;

   // A pressed key shorts its row line to its column line.
   always_comb begin
      col = 4'b1111;
      for (int r = 0; r < 4; r++) begin
         for (int c = 0; c < 4; c++) begin
            if (!row[r] && keys[r*4+c]) begin
               col[c] = 1'b0;
            end
         end
      end
   end

   // Cycles since reset release; the expected row follows directly from it.
   always @(posedge clk) k <= rst ? 0 : k + 1;

   always @(negedge clk) begin
      if (!rst && key_valid && key_ready) begin
         ev_count  = ev_count + 1;
         last_code = key_code;
      end
   end

   task checkOutput(input string tag, input logic [15:0] obs, input logic [15:0] expv);
      vectors = vectors + 1;
      assert (obs === expv) else begin
         miscompares = miscompares + 1;
         $error("[TB] FAIL %s: observed %0h, expected %0h", tag, obs, expv);
      end
   endtask

   task applyStimulus(input int n);
      logic [3:0] one;
      one = 4'b0001;
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
         checkOutput("row", {12'h0, row}, {12'h0, ~(one << ((k / SCAN) % 4))});
      end
   endtask

   task applyReset(input int n);
      rst = 1'b1;
      repeat (n) @(posedge clk);
      #1;
      checkOutput("rst_row",      {12'h0, row},       16'h000E);
      checkOutput("rst_valid",    {15'h0, key_valid}, 16'h0000);
      checkOutput("rst_code",     {12'h0, key_code},  16'h0000);
      checkOutput("rst_overflow", {15'h0, overflow},  16'h0000);
      rst = 1'b0;
   endtask

   initial begin
      $display("[TB] keypad_scan_ctrl bench, SCAN_CNT=%0d DEB_FRAMES=%0d", SCAN, DEB);
      applyReset(3);

      // Key 6 held from reset release: event visible right after the frame-2 end sample.
      keys = 16'h0040;
      applyStimulus(79);
      checkOutput("hold6_early", {15'h0, key_valid}, 16'h0000);
      applyStimulus(1);
      checkOutput("hold6_valid", {15'h0, key_valid}, 16'h0001);
      checkOutput("hold6_code",  {12'h0, key_code},  16'h0006);
      applyStimulus(1);
      checkOutput("hold6_clear", {15'h0, key_valid}, 16'h0000);
      checkOutput("hold6_count", 16'(ev_count),      16'd1);
      applyStimulus(200);
      checkOutput("hold6_norep", 16'(ev_count),      16'd1);
      keys = 16'h0000;
      applyStimulus(120);
      checkOutput("rel6_noev",   16'(ev_count),      16'd1);

      // Bouncing contact on key 6 shorter than a frame.
      applyStimulus(2);
      repeat (10) begin
         #30;
         keys[6] = ~keys[6];
      end
      keys = 16'h0000;
      applyStimulus(62);
      checkOutput("bounce_noev",  16'(ev_count),      16'd1);
      checkOutput("bounce_valid", {15'h0, key_valid}, 16'h0000);
      checkOutput("bounce_ovf",   {15'h0, overflow},  16'h0000);

      // Keys 6 and 9 together, then 9 released.
      keys = 16'h0240;
      applyStimulus(400);
      checkOutput("multi_noev",  16'(ev_count),      16'd1);
      checkOutput("multi_valid", {15'h0, key_valid}, 16'h0000);
      keys = 16'h0040;
      applyStimulus(79);
      checkOutput("single_early", {15'h0, key_valid}, 16'h0000);
      applyStimulus(1);
      checkOutput("single_valid", {15'h0, key_valid}, 16'h0001);
      checkOutput("single_code",  {12'h0, key_code},  16'h0006);
      applyStimulus(1);
      checkOutput("single_count", 16'(ev_count),      16'd2);
      checkOutput("single_last",  {12'h0, last_code}, 16'h0006);
      keys = 16'h0000;
      applyStimulus(80);

      // Consumer stalled: key 3 is held, key 12 is dropped.
      key_ready = 1'b0;
      keys = 16'h0008;
      applyStimulus(78);
      checkOutput("k3_early", {15'h0, key_valid}, 16'h0000);
      applyStimulus(1);
      checkOutput("k3_valid", {15'h0, key_valid}, 16'h0001);
      checkOutput("k3_code",  {12'h0, key_code},  16'h0003);
      applyStimulus(81);
      checkOutput("k3_noovf", {15'h0, overflow},  16'h0000);
      keys = 16'h0000;
      applyStimulus(160);
      keys = 16'h1000;
      applyStimulus(160);
      keys = 16'h0000;
      applyStimulus(160);
      checkOutput("drop_valid", {15'h0, key_valid}, 16'h0001);
      checkOutput("drop_code",  {12'h0, key_code},  16'h0003);
      checkOutput("drop_ovf",   {15'h0, overflow},  16'h0001);
      key_ready = 1'b1;
      applyStimulus(1);
      key_ready = 1'b0;
      checkOutput("drain_valid", {15'h0, key_valid}, 16'h0000);
      checkOutput("drain_count", 16'(ev_count),      16'd3);
      checkOutput("drain_last",  {12'h0, last_code}, 16'h0003);
      checkOutput("drain_ovf",   {15'h0, overflow},  16'h0001);

      // Ready while idle changes nothing.
      key_ready = 1'b1;
      applyStimulus(3);
      checkOutput("idle_valid", {15'h0, key_valid}, 16'h0000);
      checkOutput("idle_code",  {12'h0, key_code},  16'h0003);
      checkOutput("idle_count", 16'(ev_count),      16'd3);

      // Key 0 pressed, reset after one frame, key kept held.
      keys = 16'h0001;
      applyStimulus(35);
      applyReset(3);
      applyStimulus(79);
      checkOutput("k0_early", {15'h0, key_valid}, 16'h0000);
      applyStimulus(1);
      checkOutput("k0_valid", {15'h0, key_valid}, 16'h0001);
      checkOutput("k0_code",  {12'h0, key_code},  16'h0000);
      applyStimulus(1);
      checkOutput("k0_count", 16'(ev_count),      16'd4);

      // New event in the same cycle as a handshake replaces the old code.
      key_ready = 1'b0;
      keys = 16'h0000;
      applyStimulus(80);
      keys = 16'h0020;
      applyStimulus(79);
      checkOutput("k5_valid", {15'h0, key_valid}, 16'h0001);
      checkOutput("k5_code",  {12'h0, key_code},  16'h0005);
      keys = 16'h0000;
      applyStimulus(81);
      keys = 16'h0400;
      applyStimulus(78);
      checkOutput("k10_pre_code", {12'h0, key_code}, 16'h0005);
      key_ready = 1'b1;
      applyStimulus(1);
      checkOutput("k10_valid", {15'h0, key_valid}, 16'h0001);
      checkOutput("k10_code",  {12'h0, key_code},  16'h000A);
      checkOutput("k10_ovf",   {15'h0, overflow},  16'h0000);
      applyStimulus(1);
      checkOutput("k10_clear", {15'h0, key_valid}, 16'h0000);
      checkOutput("k10_count", 16'(ev_count),      16'd6);
      checkOutput("k10_last",  {12'h0, last_code}, 16'h000A);

      // Key 15 press / release / press.
      keys = 16'h0000;
      applyStimulus(80);
      keys = 16'h8000;
      applyStimulus(79);
      checkOutput("k15a_valid", {15'h0, key_valid}, 16'h0001);
      checkOutput("k15a_code",  {12'h0, key_code},  16'h000F);
      applyStimulus(41);
      keys = 16'h0000;
      applyStimulus(120);
      keys = 16'h8000;
      applyStimulus(79);
      checkOutput("k15b_valid", {15'h0, key_valid}, 16'h0001);
      checkOutput("k15b_code",  {12'h0, key_code},  16'h000F);
      applyStimulus(41);
      checkOutput("k15_count", 16'(ev_count),      16'd8);
      checkOutput("k15_last",  {12'h0, last_code}, 16'h000F);
      checkOutput("k15_ovf",   {15'h0, overflow},  16'h0000);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
